// File: rtl/debounce_sync.sv
// debounce_sync: synchronizer chain followed by a consecutive-sample qualifier.
// Define DEBOUNCE_SYNC_EDGE_OUT_EN to add the registered edge pulses re_o / fe_o.
module debounce_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 d_i,
  input  logic [CNT_WIDTH-1:0] thresh_i,
  output logic                 q_o,
  output logic                 busy_o
`ifdef DEBOUNCE_SYNC_EDGE_OUT_EN
  ,
  output logic                 re_o,
  output logic                 fe_o
`endif
);

  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  state_t                 state_r;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic                   q_r;
  logic                   busy_r;

  // Synchronizer chain, clocked regardless of en_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_r <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d_i};
    end
  end

  assign s_s = sync_r[SYNC_STAGES-1];

  // Qualification FSM; a bounce back to q_r wins over reaching the threshold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= STABLE;
      cnt_r   <= CNT_ZERO;
      q_r     <= RESET_VALUE;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        STABLE: begin
          if (en_i && (s_s != q_r)) begin
            if (thresh_i == CNT_ZERO) begin
              q_r <= s_s;
            end else begin
              state_r <= QUALIFY;
              cnt_r   <= CNT_ONE;
              busy_r  <= 1'b1;
            end
          end
        end
        QUALIFY: begin
          if (!en_i) begin
            state_r <= QUALIFY;
          end else if (s_s == q_r) begin
            state_r <= STABLE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
          end else if (cnt_r >= thresh_i) begin
            q_r     <= s_s;
            state_r <= STABLE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= STABLE;
          cnt_r   <= CNT_ZERO;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign q_o    = q_r;
  assign busy_o = busy_r;

`ifdef DEBOUNCE_SYNC_EDGE_OUT_EN
  logic q_q_r;
  logic re_r;
  logic fe_r;

  // Edge pulses one cycle after q_r changes; q_q_r resets to match q_r so release emits nothing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q_r <= RESET_VALUE;
      re_r  <= 1'b0;
      fe_r  <= 1'b0;
    end else begin
      q_q_r <= q_r;
      re_r  <= q_r & ~q_q_r;
      fe_r  <= ~q_r & q_q_r;
    end
  end

  assign re_o = re_r;
  assign fe_o = fe_r;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_debounce_sync;

  localparam int CW = 8;

  logic          clk_i    = 1'b0;
  logic          rst_ni   = 1'b1;
  logic          en_i     = 1'b1;
  logic          d_i      = 1'b0;
  logic [CW-1:0] thresh_i = 8'd0;
  logic          q_o;
  logic          busy_o;
`ifdef DEBOUNCE_SYNC_EDGE_OUT_EN
  logic          re_o;
  logic          fe_o;
`endif

  debounce_sync #(
    .SYNC_STAGES(2),
    .CNT_WIDTH  (CW),
    .RESET_VALUE(1'b0)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (en_i),
    .d_i     (d_i),
    .thresh_i(thresh_i),
    .q_o     (q_o),
    .busy_o  (busy_o)
`ifdef DEBOUNCE_SYNC_EDGE_OUT_EN
    ,
    .re_o    (re_o),
    .fe_o    (fe_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    logic  q;
    logic  b;
    logic  re;
    logic  fe;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic q, input logic b,
                       input logic re, input logic fe);
    logic [3:0] act;
    logic [3:0] req;
`ifdef DEBOUNCE_SYNC_EDGE_OUT_EN
    act = {q_o, busy_o, re_o, fe_o};
    req = {q, b, re, fe};
`else
    act = {q_o, busy_o, 2'b00};
    req = {q, b, 2'b00};
`endif
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: {q,busy,re,fe} got %b required %b", tag, cyc, act, req);
  endtask

  always @(negedge clk_i) begin : monitor
    exp_t e;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        n_checks++;
        $display("FAIL %s stale expectation for cycle %0d seen at %0d", e.tag, e.cyc, cyc);
      end else begin
        check(e.tag, e.q, e.b, e.re, e.fe);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_i);
      #1;
    end
  endtask

  task automatic push(input int c, input logic q, input logic b,
                      input logic re, input logic fe, input string tag);
    exp_t e;
    e.cyc = c; e.q = q; e.b = b; e.re = re; e.fe = fe; e.tag = tag;
    sb.push_back(e);
  endtask

  // Return q_o to 0 quickly with a zero threshold.
  task automatic fall0(input string tag);
    int c;
    c = cyc;
    thresh_i = 8'd0;
    d_i = 1'b0;
    for (int k = 1; k <= 4; k++) push(c + k, k < 3, 1'b0, 1'b0, k == 4, tag);
    step(4);
  endtask

  initial begin
    int c;

    #1 rst_ni = 1'b0;
    d_i = 1'b1;
    thresh_i = 8'd3;
    #1 check("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) push(k, 1'b0, 1'b0, 1'b0, 1'b0, "reset_hold");
    step(3);
    d_i = 1'b0;
    rst_ni = 1'b1;
    step(2);

    // Clean step, thresh 3: q rises 6 edges after the step.
    c = cyc;
    d_i = 1'b1;
    for (int k = 1; k <= 10; k++)
      push(c + k, k >= 6, (k >= 3) && (k <= 5), k == 7, 1'b0, "clean_rise");
    step(10);
    c = cyc;
    d_i = 1'b0;
    for (int k = 1; k <= 10; k++)
      push(c + k, k < 6, (k >= 3) && (k <= 5), 1'b0, k == 7, "clean_fall");
    step(10);

    // Bounce rejection, thresh 4.
    c = cyc;
    thresh_i = 8'd4;
    for (int k = 1; k <= 26; k++)
      push(c + k, 1'b0, (k >= 3) && (k <= 22) && ((k - 3) % 2 == 0), 1'b0, 1'b0, "bounce");
    for (int j = 0; j < 20; j++) begin
      d_i = (j % 2 == 0);
      step(1);
    end
    d_i = 1'b0;
    step(6);

    // Zero threshold, single-cycle pulse.
    c = cyc;
    thresh_i = 8'd0;
    for (int k = 1; k <= 6; k++) push(c + k, k == 3, 1'b0, k == 4, k == 5, "zero_thresh");
    d_i = 1'b1;
    step(1);
    d_i = 1'b0;
    step(5);

    // Enable freeze mid-qualify, thresh 5.
    c = cyc;
    thresh_i = 8'd5;
    for (int k = 1; k <= 20; k++)
      push(c + k, k >= 18, (k >= 3) && (k <= 17), k == 19, 1'b0, "en_freeze");
    d_i = 1'b1;
    step(4);
    en_i = 1'b0;
    step(10);
    en_i = 1'b1;
    step(6);
    fall0("en_freeze_fall");

    // Enable low while stable: q holds, re-enable qualifies fresh.
    c = cyc;
    thresh_i = 8'd1;
    for (int k = 1; k <= 11; k++)
      push(c + k, k >= 8, k == 7, k == 9, 1'b0, "en_stable");
    en_i = 1'b0;
    d_i = 1'b1;
    step(6);
    en_i = 1'b1;
    step(5);
    fall0("en_stable_fall");

    // Bounce at the same cycle the count reaches thresh: no toggle.
    c = cyc;
    thresh_i = 8'd1;
    for (int k = 1; k <= 7; k++) push(c + k, 1'b0, k == 3, 1'b0, 1'b0, "bounce_prio");
    d_i = 1'b1;
    step(1);
    d_i = 1'b0;
    step(6);

    // Threshold lowered mid-qualify qualifies on the next enabled cycle.
    c = cyc;
    thresh_i = 8'd6;
    for (int k = 1; k <= 7; k++)
      push(c + k, k >= 5, (k == 3) || (k == 4), k == 6, 1'b0, "thresh_lower");
    d_i = 1'b1;
    step(4);
    thresh_i = 8'd1;
    step(3);
    fall0("thresh_lower_fall");

    // Reset at cnt=5, thresh 8; a full 9-sample count is needed after release.
    c = cyc;
    thresh_i = 8'd8;
    for (int k = 1; k <= 21; k++)
      push(c + k, k >= 20, ((k >= 3) && (k <= 7)) || ((k >= 12) && (k <= 19)),
           k == 21, 1'b0, "reset_mid");
    d_i = 1'b1;
    step(7);
    rst_ni = 1'b0;
    #1 check("reset_mid_async", 1'b0, 1'b0, 1'b0, 1'b0);
    step(2);
    rst_ni = 1'b1;
    step(12);
    fall0("reset_mid_fall");

    begin : drain
      int k;
      k = 0;
      while (sb.size() != 0 && k < 50) begin
        step(1);
        k++;
      end
      if (sb.size() != 0) begin
        n_checks++;
        $display("FAIL drain: %0d expectations left, required 0", sb.size());
        sb.delete();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
